// File: rtl/dpd_sample_aligner.sv
// DPD actuator-path sample aligner: programmable valid-beat delay
// over a circular buffer, with fill/run sequencing and lock status.
module dpd_sample_aligner #(
  parameter int DWIDTH = 32,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_load,
  input  logic [AW-1:0]     delay_cfg,
  input  logic              din_valid,
  input  logic [DWIDTH-1:0] din,
  output logic              dout_valid,
  output logic [DWIDTH-1:0] dout,
  output logic              locked,
  output logic [AW-1:0]     delay_active
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    FILL,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     fill_q, fill_d;
  logic [AW-1:0]     dly_q, dly_d;
  logic [AW-1:0]     rd_addr;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] tap;
  logic              vld_q;
  logic              lock_q, lock_d;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Zero delay bypasses the buffer so the current beat is output directly.
  assign rd_addr = wr_ptr_q - dly_q;
  assign tap     = (dly_q == '0) ? din : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (din_valid) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // A load coinciding with a beat lets that beat use the old rule,
  // but the load owns delay, fill count, state and lock.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    dly_d    = dly_q;
    lock_d   = lock_q;
    dout_d   = dout_q;
    wr_ptr_d = wr_ptr_q;
    if (din_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      unique case (state_q)
        FILL: begin
          if (fill_q == dly_q) begin
            dout_d  = tap;
            state_d = RUN;
            lock_d  = 1'b1;
          end else begin
            dout_d = '0;
            fill_d = fill_q + 1'b1;
          end
        end
        RUN: begin
          dout_d = tap;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
    if (cfg_load) begin
      dly_d   = delay_cfg;
      fill_d  = '0;
      state_d = FILL;
      lock_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      dly_q    <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      dly_q    <= dly_d;
      dout_q   <= dout_d;
      vld_q    <= din_valid;
      lock_q   <= lock_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = vld_q;
  assign locked       = lock_q;
  assign delay_active = dly_q;

endmodule

// File: doc/dpd_sample_aligner.md
Name: dpd_sample_aligner

Overview:
- Runtime-programmable, valid-qualified sample delay for I/Q data on the DPD actuator input path.
- Sits directly upstream of the fixed-tap delay line. It aligns the actuator input stream to the capture/feedback path by a software-selected number of samples, then hands the aligned stream to the fixed delay.
- Implemented as a circular buffer with a fill/run state machine. It reports when a programmed delay is fully in effect.

Parameters:
- DWIDTH, 32, sample width (I and Q packed, 16+16).
- AW, 6, buffer address width; buffer depth = 2^AW; maximum delay = 2^AW-1 samples.

Ports:
- clk  input  1  sample clock.
- rstn  input  1  asynchronous active-low reset.
- cfg_load  input  1  one-cycle strobe; latches delay_cfg.
- delay_cfg  input  AW  requested delay in valid samples (0..2^AW-1).
- din_valid  input  1  input sample qualifier.
- din  input  DWIDTH  input sample.
- dout_valid  output  1  output sample qualifier.
- dout  output  DWIDTH  aligned sample.
- locked  output  1  high when dout carries true delayed data at the active delay.
- delay_active  output  AW  delay currently in effect.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_valid=0, locked=0, delay_active=0, wr_ptr=0, fill_cnt=0, state=FILL. Buffer contents are don't-care.
- Delay counts valid beats, not clocks. Idle cycles (din_valid=0) do not advance the pointer, counters or output.
- Write: each din_valid beat writes din at wr_ptr, then wr_ptr increments modulo 2^AW (natural wrap).
- Read address = wr_ptr - delay_active, computed modulo 2^AW.
- delay_active=0: dout is a copy of the current din, via a bypass path that does not read the buffer.
- Latency: dout/dout_valid are registered. A beat presented at cycle t produces dout_valid=1 at t+1, independent of delay.
  - dout at beat n = din at beat n-delay_active (RUN state).
  - dout_valid = din_valid delayed 1 clk in every state.
  - When din_valid=0, dout holds its last value.
- State machine:
  - FILL: each valid beat increments fill_cnt; dout is forced to 0 on each beat; locked=0. When a beat arrives with fill_cnt == delay_active, go to RUN. That beat's output is real data.
  - FILL with delay_active=0 goes to RUN on the first valid beat.
  - RUN: dout = buffer/bypass data; locked=1 from the cycle after the transition beat's output, i.e. aligned with that beat's dout_valid.
- cfg_load in any state:
  - delay_active <= delay_cfg on the next edge; fill_cnt <= 0; state <= FILL; locked drops the next cycle.
  - wr_ptr is NOT reset.
  - The new delay takes effect on the beat after the load.
  - A cfg_load coinciding with a din_valid beat: that beat is written. It is output at the OLD delay with the old state's rule, and is not counted toward the new fill.
  - Reloading the same value still re-enters FILL.
- Zero-forcing in FILL ensures stale buffer data never reaches the actuator.
- Back-to-back cfg_load strobes: the last one wins; fill restarts each time.
- Reset mid-operation: all state returns to reset values immediately. Any beat in flight is dropped.

Test Plan:
1. Reset, cfg_load delay_cfg=0, stream din=1,2,3 continuous. Required: dout_valid at t+1; dout=1,2,3; locked=1 from the first output.
2. delay_cfg=4, continuous ramp din=1..20. Required: first 4 outputs = 0 with locked=0; 5th output = 1; then dout = din-4 through 20; locked=1 from the 5th output.
3. delay_cfg=3, din_valid toggling 1,0,1,0, ramp 1..12. Required: dout_valid mirrors din_valid one clk later; valid outputs 0,0,0,1,2,...; dout holds during gaps.
4. delay_cfg=63 (max), 200-beat ramp to force pointer wrap. Required: outputs 1..63 = 0; beat k≥64 outputs k-63; no glitch at wrap.
5. Running locked at delay=5; cfg_load delay_cfg=2 coincident with a valid beat. Required: that beat's output uses delay 5; locked=0 next cycle; next 2 outputs = 0; then dout = din-2, locked=1.
6. Assert rstn=0 mid-stream at delay=8, release after 3 clks, then reload delay=8 and resume. Required: dout/dout_valid/locked = 0 asynchronously; 8 zero outputs before aligned data; no pre-reset samples appear.
